// File: rtl/i2s_pkg.sv
// Shared I2S definitions: serial format codes and a constant-width helper
// used by the transmitter and its bit-clock generator.
package i2s_pkg;

  localparam logic [1:0] I2S_MODE_I2S = 2'd0;
  localparam logic [1:0] I2S_MODE_LJ  = 2'd1;
  localparam logic [1:0] I2S_MODE_RJ  = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides i_mclk by MCLK_DIV into a registered BCLK and
// strobes o_fe on the i_mclk cycle whose edge drives BCLK from 1 to 0.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int MCLK_DIV = 2
) (
  input  logic i_mclk,
  input  logic i_rst_x,
  output logic o_bclk,
  output logic o_fe
);

  localparam int DIV_W = (clog2(MCLK_DIV) < 1) ? 1 : clog2(MCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic [DIV_W-1:0] w_div_nxt;

  assign o_fe      = (r_div == DIV_LAST);
  assign w_div_nxt = o_fe ? '0 : r_div + 1'b1;
  assign o_bclk    = r_bclk;

  // BCLK is registered from the next count so it always matches r_div's half.
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_bclk <= (w_div_nxt >= DIV_HALF);
    end
  end

endmodule

// File: rtl/i2s_tx_core.sv
// Stereo I2S / left-justified / right-justified transmitter with a one-deep
// shadow buffer. Build option I2S_TX_UNDERRUN_HOLD_EN repeats the last pair on underrun.
module i2s_tx_core
  import i2s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 2
) (
  input  logic              i_mclk,
  input  logic              i_rst_x,
  input  logic [1:0]        i_mode,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data_l,
  input  logic [DATA_W-1:0] i_data_r,
  output logic              o_bclk,
  output logic              o_lrclk,
  output logic              o_sdata,
  output logic              o_underrun
);

  localparam int B_W = clog2(2 * SLOT_W);
  localparam logic [B_W-1:0] B_LAST = B_W'(2 * SLOT_W - 1);
  localparam logic [B_W-1:0] B_SLOT = B_W'(SLOT_W);

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam bit HOLD_ON_UNDERRUN = 1'b1;
`else
  localparam bit HOLD_ON_UNDERRUN = 1'b0;
`endif

  logic              w_fe;
  logic              w_frame_start;
  logic              w_accept;
  logic [B_W-1:0]    w_b_nxt;
  logic              w_half;
  logic [B_W-1:0]    w_pos;
  logic [1:0]        w_mode_nxt;
  logic [DATA_W-1:0] w_frame_l_nxt;
  logic [DATA_W-1:0] w_frame_r_nxt;
  logic              w_lrclk_nxt;
  logic              w_sdata_nxt;

  logic [B_W-1:0]    r_b;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_frame_l;
  logic [DATA_W-1:0] r_frame_r;
  logic [DATA_W-1:0] r_shadow_l;
  logic [DATA_W-1:0] r_shadow_r;
  logic              r_full;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_underrun;

  i2s_bclk_gen #(.MCLK_DIV(MCLK_DIV)) u_bclk_gen (
    .i_mclk  (i_mclk),
    .i_rst_x (i_rst_x),
    .o_bclk  (o_bclk),
    .o_fe    (w_fe)
  );

  // Bit at slot position p: the data window starts at a mode-dependent offset.
  function automatic logic slot_bit(input logic [1:0] mode,
                                    input logic [DATA_W-1:0] smp,
                                    input logic [B_W-1:0] p);
    logic [B_W-1:0]    off;
    logic [B_W-1:0]    k;
    logic [DATA_W-1:0] sh;
    case (mode)
      I2S_MODE_LJ: off = '0;
      I2S_MODE_RJ: off = B_W'(SLOT_W - DATA_W);
      default:     off = B_W'(1);
    endcase
    k  = p - off;
    sh = smp << k;
    if ((p >= off) && (k < B_W'(DATA_W))) return sh[DATA_W-1];
    return 1'b0;
  endfunction

  // Handshake: a pair transfers on any i_mclk edge with i_valid && o_ready;
  // o_ready is high exactly while the shadow buffer is empty.
  assign o_ready       = !r_full;
  assign w_accept      = i_valid && !r_full;
  assign w_frame_start = w_fe && (r_b == B_LAST);
  assign w_b_nxt       = (r_b == B_LAST) ? '0 : r_b + 1'b1;
  assign w_half        = (w_b_nxt >= B_SLOT);
  assign w_pos         = w_half ? w_b_nxt - B_SLOT : w_b_nxt;

  always_comb begin
    w_mode_nxt    = r_mode;
    w_frame_l_nxt = r_frame_l;
    w_frame_r_nxt = r_frame_r;
    if (w_frame_start) begin
      w_mode_nxt = (i_mode == 2'd3) ? I2S_MODE_I2S : i_mode;
      if (r_full) begin
        w_frame_l_nxt = r_shadow_l;
        w_frame_r_nxt = r_shadow_r;
      end else if (!HOLD_ON_UNDERRUN) begin
        w_frame_l_nxt = '0;
        w_frame_r_nxt = '0;
      end
    end
  end

  // Outputs for the incoming bit use the post-frame-start mode and samples.
  always_comb begin
    w_lrclk_nxt = (w_mode_nxt == I2S_MODE_I2S) ? w_half : !w_half;
    w_sdata_nxt = slot_bit(w_mode_nxt, w_half ? w_frame_r_nxt : w_frame_l_nxt, w_pos);
  end

  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_b        <= '0;
      r_mode     <= I2S_MODE_I2S;
      r_frame_l  <= '0;
      r_frame_r  <= '0;
      r_shadow_l <= '0;
      r_shadow_r <= '0;
      r_full     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start && !r_full;
      r_full     <= w_accept || (r_full && !w_frame_start);
      if (w_accept) begin
        r_shadow_l <= i_data_l;
        r_shadow_r <= i_data_r;
      end
      if (w_fe) begin
        r_b       <= w_b_nxt;
        r_mode    <= w_mode_nxt;
        r_frame_l <= w_frame_l_nxt;
        r_frame_r <= w_frame_r_nxt;
        r_lrclk   <= w_lrclk_nxt;
        r_sdata   <= w_sdata_nxt;
      end
    end
  end

  assign o_lrclk    = r_lrclk;
  assign o_sdata    = r_sdata;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx_core.sv
// Directed bench for i2s_tx_core: default 16/32/div2 instance plus a
// 24-bit RJ, MCLK_DIV=4 instance; frames are captured at BCLK rising edges.
`timescale 1ns/1ps
module tb_i2s_tx_core;

  // ---------------- clock / reset ----------------
  logic mclk = 1'b0;
  always #5 mclk = ~mclk;
  logic rst0_x, rst1_x;

  logic [1:0]  mode0, mode1;
  logic        valid0, valid1, ready0, ready1;
  logic [15:0] dl0, dr0;
  logic [23:0] dl1, dr1;
  logic        bclk0, lr0, sd0, ur0;
  logic        bclk1, lr1, sd1, ur1;

  i2s_tx_core u_dut0 (
    .i_mclk(mclk), .i_rst_x(rst0_x), .i_mode(mode0), .i_valid(valid0), .o_ready(ready0),
    .i_data_l(dl0), .i_data_r(dr0), .o_bclk(bclk0), .o_lrclk(lr0), .o_sdata(sd0),
    .o_underrun(ur0)
  );

  i2s_tx_core #(.DATA_W(24), .SLOT_W(32), .MCLK_DIV(4)) u_dut1 (
    .i_mclk(mclk), .i_rst_x(rst1_x), .i_mode(mode1), .i_valid(valid1), .o_ready(ready1),
    .i_data_l(dl1), .i_data_r(dr1), .o_bclk(bclk1), .o_lrclk(lr1), .o_sdata(sd1),
    .o_underrun(ur1)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(negedge mclk) cyc <= cyc + 1;

  logic cap0_sd [0:15][0:63];
  logic cap0_lr [0:15][0:63];
  logic cap1_sd [0:15][0:63];
  logic cap1_lr [0:15][0:63];
  int   t0 [0:15];
  int   t1 [0:15];
  int   bit0, bit1;
  int   urc0 [0:15];
  int   urc1 [0:15];

  always @(posedge bclk0 or negedge rst0_x) begin
    if (!rst0_x) bit0 <= 0;
    else begin
      if (bit0 < 1024) begin
        cap0_sd[bit0/64][bit0%64] <= sd0;
        cap0_lr[bit0/64][bit0%64] <= lr0;
        if (bit0 % 64 == 0) t0[bit0/64] <= cyc;
      end
      bit0 <= bit0 + 1;
    end
  end

  always @(posedge bclk1 or negedge rst1_x) begin
    if (!rst1_x) bit1 <= 0;
    else begin
      if (bit1 < 1024) begin
        cap1_sd[bit1/64][bit1%64] <= sd1;
        cap1_lr[bit1/64][bit1%64] <= lr1;
        if (bit1 % 64 == 0) t1[bit1/64] <= cyc;
      end
      bit1 <= bit1 + 1;
    end
  end

  always @(negedge mclk) begin
    if (!rst0_x) for (int i = 0; i < 16; i++) urc0[i] <= 0;
    else if (ur0 && bit0 / 64 < 16) urc0[bit0/64] <= urc0[bit0/64] + 1;
    if (!rst1_x) for (int i = 0; i < 16; i++) urc1[i] <= 0;
    else if (ur1 && bit1 / 64 < 16) urc1[bit1/64] <= urc1[bit1/64] + 1;
  end

  // sdata/lrclk on the MCLK_DIV=4 instance may only move right after BCLK falls
  logic p_sd1 = 1'b0, p_lr1 = 1'b0, p_bclk1 = 1'b0;
  int   viol1 = 0;
  always @(negedge mclk) begin
    if (rst1_x && ((sd1 !== p_sd1) || (lr1 !== p_lr1)) && !(p_bclk1 && !bclk1))
      viol1 <= viol1 + 1;
    p_sd1   <= sd1;
    p_lr1   <= lr1;
    p_bclk1 <= bclk1;
  end

  int cyc1;
  always @(posedge mclk or negedge rst1_x) begin
    if (!rst1_x) cyc1 <= 0;
    else cyc1 <= cyc1 + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_bits(input int which, input int n);
    int guard;
    guard = 0;
    while (((which == 0) ? bit0 : bit1) < n && guard < 20000) begin
      @(negedge mclk);
      guard++;
    end
    if (guard >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_bits%0d: timed out at %0d bits, required %0d", which,
               (which == 0) ? bit0 : bit1, n);
    end
  endtask

  task automatic offer0(input logic [1:0] m, input logic [15:0] l, input logic [15:0] r);
    int guard;
    guard = 0;
    @(negedge mclk);
    while (!ready0 && guard < 2000) begin
      @(negedge mclk);
      guard++;
    end
    if (guard >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL offer0_ready: o_ready stayed 0, required 1 within 2000 cycles");
    end
    valid0 = 1'b1;
    dl0    = l;
    dr0    = r;
    mode0  = m;
    @(negedge mclk);
    valid0 = 1'b0;
  endtask

  task automatic check_frame(input int which, input string name, input int f,
                             input logic [31:0] lw, input logic [31:0] rw, input logic lr_left);
    logic [63:0] d;
    logic [63:0] l;
    d = '0;
    l = '0;
    for (int p = 0; p < 64; p++) begin
      d = {d[62:0], (which == 0) ? cap0_sd[f][p] : cap1_sd[f][p]};
      l = {l[62:0], (which == 0) ? cap0_lr[f][p] : cap1_lr[f][p]};
    end
    check({name, "_data"}, d, {lw, rw});
    check({name, "_lrclk"}, l, {{32{lr_left}}, {32{~lr_left}}});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] lw;
    logic [31:0] rw;
    logic        lr_left;
  } vec_t;

  vec_t vecs [0:5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded 2 ms");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0]  shape;
    logic [31:0] ul, urw;
    int          guard;

    vecs[0] = '{2'd0, 16'hA5F0, 16'h0F5A, 32'h52F8_0000, 32'h07AD_0000, 1'b0};
    vecs[1] = '{2'd1, 16'hA5F0, 16'h0F5A, 32'hA5F0_0000, 32'h0F5A_0000, 1'b1};
    vecs[2] = '{2'd2, 16'hA5F0, 16'h0F5A, 32'h0000_A5F0, 32'h0000_0F5A, 1'b1};
    vecs[3] = '{2'd3, 16'h8001, 16'h7FFE, 32'h4000_8000, 32'h3FFF_0000, 1'b0};
    vecs[4] = '{2'd1, 16'h8001, 16'h7FFE, 32'h8001_0000, 32'h7FFE_0000, 1'b1};
    vecs[5] = '{2'd2, 16'h8001, 16'h7FFE, 32'h0000_8001, 32'h0000_7FFE, 1'b1};
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    ul  = vecs[5].lw;
    urw = vecs[5].rw;
`else
    ul  = 32'h0;
    urw = 32'h0;
`endif

    rst0_x = 1'b0; rst1_x = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    mode0 = 2'd0; mode1 = 2'd0;
    dl0 = '0; dr0 = '0; dl1 = '0; dr1 = '0;
    repeat (3) @(negedge mclk);
    check("reset_outputs0", 64'({bclk0, lr0, sd0, ur0, ready0}), 64'(5'b00001));
    rst0_x = 1'b1;

    // Default instance: one pair per frame, then let the shadow run dry.
    for (int k = 0; k < 6; k++) offer0(vecs[k].mode, vecs[k].l, vecs[k].r);
    wait_bits(0, 8 * 64);
    check_frame(0, "frame0_zero", 0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++)
      check_frame(0, $sformatf("vec%0d", k), k + 1, vecs[k].lw, vecs[k].rw, vecs[k].lr_left);
    check_frame(0, "underrun_frame", 7, ul, urw, 1'b1);
    check("underrun_none_f0_6", 64'(urc0[0] + urc0[1] + urc0[2] + urc0[3] + urc0[4] +
                                    urc0[5] + urc0[6]), 64'd0);
    check("underrun_pulse_f7", 64'(urc0[7]), 64'd1);
    check("lrclk_period0", 64'(t0[2] - t0[1]), 64'd128);

    // Reset mid-frame with a pair waiting in the shadow.
    rst0_x = 1'b0;
    repeat (2) @(negedge mclk);
    rst0_x = 1'b1;
    offer0(2'd1, 16'h8001, 16'h7FFE);
    offer0(2'd1, 16'h1234, 16'h5678);
    wait_bits(0, 64 + 21);
    check("pre_reset_state", 64'({bclk0, lr0, ready0}), 64'(3'b110));
    #2 rst0_x = 1'b0;
    #1 check("async_reset_outputs", 64'({bclk0, lr0, sd0, ur0, ready0}), 64'(5'b00001));
    @(negedge mclk);
    @(negedge mclk);
    rst0_x = 1'b1;
    wait_bits(0, 2 * 64);
    check_frame(0, "post_reset_f0", 0, 32'h0, 32'h0, 1'b0);
    check_frame(0, "post_reset_f1", 1, 32'h0, 32'h0, 1'b1);
    check("post_reset_no_ur_f0", 64'(urc0[0]), 64'd0);
    check("post_reset_ur_f1", 64'(urc0[1]), 64'd1);

    // 24-bit RJ instance, MCLK_DIV=4: bclk shape, backpressure, window.
    @(negedge mclk);
    rst1_x = 1'b1;
    shape = '0;
    for (int i = 0; i < 8; i++) begin
      shape = {shape[6:0], bclk1};
      @(negedge mclk);
    end
    check("bclk_shape_div4", 64'(shape), 64'(8'b0011_0011));
    valid1 = 1'b1; dl1 = 24'h800001; dr1 = 24'h123456; mode1 = 2'd2;
    @(negedge mclk);
    check("bp_ready_low", 64'(ready1), 64'd0);
    dl1 = 24'h7FFFFE; dr1 = 24'hC00003;
    guard = 0;
    while (!ready1 && guard < 1000) begin
      @(negedge mclk);
      guard++;
    end
    check("bp_accept_cycle", 64'(cyc1), 64'd256);
    @(negedge mclk);
    valid1 = 1'b0;
    wait_bits(1, 3 * 64);
    check_frame(1, "rj24_f0", 0, 32'h0, 32'h0, 1'b0);
    check_frame(1, "rj24_f1", 1, 32'h0080_0001, 32'h0012_3456, 1'b1);
    check_frame(1, "rj24_f2", 2, 32'h007F_FFFE, 32'h00C0_0003, 1'b1);
    check("lrclk_period1", 64'(t1[2] - t1[1]), 64'd256);
    check("data_only_on_fe", 64'(viol1), 64'd0);
    check("underrun_none_rj24", 64'(urc1[0] + urc1[1] + urc1[2]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
